flash_boot_loader: RTL and testbench

- Standalone, parametrised successor of the core's boot sequence. After reset it reads a region of SPI NOR flash and copies it word by word into 'ramio'. It then raises 'done' so the CPU, or an arbiter muxing 'ramio', can start.
- Adds the following over the core's fixed boot sequence:
  - configurable SPI clock divider
  - optional fast-read mode
  - configurable RAM destination
  - re-run on request
  - status outputs

---
 rtl/flash_boot_pkg.sv | 27 ++
 rtl/flash_boot_loader_spi_shifter.sv | 79 +++++++
 rtl/flash_boot_loader.sv | 205 ++++++++++++++++++++
 tb/tb_flash_boot_loader.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_boot_pkg.sv
// Shared types and constants for the flash boot loader.
package flash_boot_pkg;

  typedef enum logic [2:0] {
    Init,
    SendCmd,
    SendAddr,
    Dummy,
    ReadData,
    StartWrite,
    Write,
    Done
  } state_e;

  localparam logic [7:0] FlashCmdRead     = 8'h03;
  localparam logic [7:0] FlashCmdFastRead = 8'h0B;

  localparam logic [1:0] RamioWriteWord = 2'b11;
  localparam logic [1:0] RamioNone      = 2'b00;

  // Bytes arrive MSB-first into a plain shift register; the first byte
  // received belongs in the low byte of the RAM word.
  function automatic logic [31:0] le_word(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/flash_boot_loader_spi_shifter.sv
// SPI mode-0 bit engine: shifts out 'count' bits of 'load' MSB first while
// shifting miso into 'rx'. 'done' is high on the cycle that ends the last bit,
// so a 'start' on that same cycle chains the next transfer with no gap.
module spi_shifter
  import flash_boot_pkg::*;
#(
  parameter int unsigned SpiClkDiv = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] load,
  input  logic [5:0]  count,
  input  logic        miso,
  output logic        flash_clk,
  output logic        mosi,
  output logic [31:0] rx,
  output logic        done
);

  localparam int unsigned DW = (SpiClkDiv > 1) ? $clog2(SpiClkDiv) : 1;
  localparam logic [DW-1:0] DivLast = DW'(SpiClkDiv - 1);

  logic          active;
  logic          phase_hi;
  logic [DW-1:0] div_cnt;
  logic [5:0]    bits_left;
  logic [31:0]   tx_sh;
  logic          half_end;

  assign half_end = active && (div_cnt == DivLast);
  assign done     = half_end && phase_hi && (bits_left == 6'd1);

  // Divider, clock phase, and tx/rx shift registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active    <= 1'b0;
      phase_hi  <= 1'b0;
      div_cnt   <= '0;
      bits_left <= '0;
      tx_sh     <= '0;
      rx        <= '0;
      flash_clk <= 1'b0;
      mosi      <= 1'b0;
    end else if (start) begin
      active    <= 1'b1;
      phase_hi  <= 1'b0;
      div_cnt   <= '0;
      bits_left <= count;
      mosi      <= load[31];
      tx_sh     <= {load[30:0], 1'b0};
      flash_clk <= 1'b0;
    end else if (active) begin
      if (!half_end) begin
        div_cnt <= div_cnt + 1'b1;
      end else begin
        div_cnt <= '0;
        if (!phase_hi) begin
          // miso is captured on the edge that raises flash_clk
          phase_hi  <= 1'b1;
          flash_clk <= 1'b1;
          rx        <= {rx[30:0], miso};
        end else begin
          phase_hi  <= 1'b0;
          flash_clk <= 1'b0;
          if (bits_left == 6'd1) begin
            active <= 1'b0;
            mosi   <= 1'b0;
          end else begin
            bits_left <= bits_left - 1'b1;
            mosi      <= tx_sh[31];
            tx_sh     <= {tx_sh[30:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: rtl/flash_boot_loader.sv
// Boot loader: copies a region of SPI NOR flash into 'ramio' word by word,
// then raises 'done'. A reload pulse in Done reruns the copy.
module flash_boot_loader
  import flash_boot_pkg::*;
#(
  parameter int unsigned StartupWaitCycles  = 10,
  parameter logic [23:0] FlashFromAddress   = 24'h0,
  parameter logic [31:0] FlashTransferBytes = 32'h0010_0000,
  parameter logic [31:0] RamioStartAddress  = 32'h0,
  parameter int unsigned SpiClkDiv          = 1,
  parameter bit          FastRead           = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reload,
  output logic        busy,
  output logic        done,
  output logic        ramio_enable,
  output logic [2:0]  ramio_read_type,
  output logic [1:0]  ramio_write_type,
  output logic [31:0] ramio_address,
  output logic [31:0] ramio_data_in,
  input  logic        ramio_busy,
  output logic        flash_clk,
  input  logic        flash_miso,
  output logic        flash_mosi,
  output logic        flash_cs
);

  if (FlashTransferBytes == 32'd0 || FlashTransferBytes[1:0] != 2'b00) begin : g_bad_len
    $error("FlashTransferBytes must be a non-zero multiple of 4");
  end
  if (RamioStartAddress[1:0] != 2'b00) begin : g_bad_ram
    $error("RamioStartAddress must be 4-aligned");
  end
  if (SpiClkDiv < 1) begin : g_bad_div
    $error("SpiClkDiv must be >= 1");
  end

  localparam logic [7:0] Cmd = FastRead ? FlashCmdFastRead : FlashCmdRead;

  state_e      state_q, state_d;
  logic [31:0] wait_q, wait_d;
  logic [31:0] off_q, off_d;
  logic [31:0] off_inc;
  logic        en_q, en_d;
  logic [1:0]  wt_q, wt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        cs_q, cs_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        sh_start;
  logic [31:0] sh_load;
  logic [5:0]  sh_count;
  logic [31:0] sh_rx;
  logic        sh_done;

  spi_shifter #(.SpiClkDiv(SpiClkDiv)) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .start     (sh_start),
    .load      (sh_load),
    .count     (sh_count),
    .miso      (flash_miso),
    .flash_clk (flash_clk),
    .mosi      (flash_mosi),
    .rx        (sh_rx),
    .done      (sh_done)
  );

  assign off_inc          = off_q + 32'd4;
  assign busy             = busy_q;
  assign done             = done_q;
  assign ramio_enable     = en_q;
  assign ramio_read_type  = 3'b000;
  assign ramio_write_type = wt_q;
  assign ramio_address    = addr_q;
  assign ramio_data_in    = data_q;
  assign flash_cs         = cs_q;

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= Init;
      wait_q  <= '0;
      off_q   <= '0;
      en_q    <= 1'b0;
      wt_q    <= RamioNone;
      addr_q  <= '0;
      data_q  <= '0;
      cs_q    <= 1'b1;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      off_q   <= off_d;
      en_q    <= en_d;
      wt_q    <= wt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Sequencing: each shifter segment is started on the cycle the previous
  // one ends, so flash_clk timing is continuous across cmd/addr/dummy/data.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    off_d    = off_q;
    en_d     = en_q;
    wt_d     = wt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    cs_d     = cs_q;
    busy_d   = busy_q;
    done_d   = done_q;
    sh_start = 1'b0;
    sh_load  = '0;
    sh_count = '0;
    case (state_q)
      Init: begin
        if (wait_q == StartupWaitCycles) begin
          state_d  = SendCmd;
          cs_d     = 1'b0;
          sh_start = 1'b1;
          sh_load  = {Cmd, 24'h0};
          sh_count = 6'd8;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      SendCmd: begin
        if (sh_done) begin
          state_d  = SendAddr;
          sh_start = 1'b1;
          sh_load  = {FlashFromAddress, 8'h0};
          sh_count = 6'd24;
        end
      end
      SendAddr: begin
        if (sh_done) begin
          state_d  = FastRead ? Dummy : ReadData;
          sh_start = 1'b1;
          sh_count = FastRead ? 6'd8 : 6'd32;
        end
      end
      Dummy: begin
        if (sh_done) begin
          state_d  = ReadData;
          sh_start = 1'b1;
          sh_count = 6'd32;
        end
      end
      ReadData: begin
        if (sh_done) state_d = StartWrite;
      end
      StartWrite: begin
        if (!ramio_busy) begin
          state_d = Write;
          en_d    = 1'b1;
          wt_d    = RamioWriteWord;
          addr_d  = RamioStartAddress + off_q;
          data_d  = le_word(sh_rx);
        end
      end
      Write: begin
        if (!ramio_busy) begin
          en_d  = 1'b0;
          wt_d  = RamioNone;
          off_d = off_inc;
          if (off_inc < FlashTransferBytes) begin
            state_d  = ReadData;
            sh_start = 1'b1;
            sh_count = 6'd32;
          end else begin
            state_d = Done;
            cs_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      Done: begin
        if (reload) begin
          state_d  = SendCmd;
          done_d   = 1'b0;
          busy_d   = 1'b1;
          off_d    = '0;
          cs_d     = 1'b0;
          sh_start = 1'b1;
          sh_load  = {Cmd, 24'h0};
          sh_count = 6'd8;
        end
      end
      default: state_d = Init;
    endcase
  end

endmodule

// File: tb/tb_flash_boot_loader.sv
// Directed bench: dut 0 = default read, SpiClkDiv=1; dut 1 = fast read from
// 0x100 to RAM 0x1000 with SpiClkDiv=3 and ramio_busy stalls on every write.
module tb_flash_boot_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst[2], reload[2], busy[2], done[2], en[2];
  logic [2:0]  rt[2];
  logic [1:0]  wt[2];
  logic [31:0] ad[2], dt[2];
  logic        rbusy[2], fclk[2], miso[2], mosi[2], cs[2];

  logic [7:0] mem [512];

  int total = 0;
  int bad = 0;

  flash_boot_loader #(
    .StartupWaitCycles(10), .FlashFromAddress(24'h0), .FlashTransferBytes(32'd8),
    .RamioStartAddress(32'h0), .SpiClkDiv(1), .FastRead(1'b0)
  ) dut0 (
    .clk(clk), .rst(rst[0]), .reload(reload[0]), .busy(busy[0]), .done(done[0]),
    .ramio_enable(en[0]), .ramio_read_type(rt[0]), .ramio_write_type(wt[0]),
    .ramio_address(ad[0]), .ramio_data_in(dt[0]), .ramio_busy(rbusy[0]),
    .flash_clk(fclk[0]), .flash_miso(miso[0]), .flash_mosi(mosi[0]), .flash_cs(cs[0])
  );

  flash_boot_loader #(
    .StartupWaitCycles(10), .FlashFromAddress(24'h000100), .FlashTransferBytes(32'd8),
    .RamioStartAddress(32'h1000), .SpiClkDiv(3), .FastRead(1'b1)
  ) dut1 (
    .clk(clk), .rst(rst[1]), .reload(reload[1]), .busy(busy[1]), .done(done[1]),
    .ramio_enable(en[1]), .ramio_read_type(rt[1]), .ramio_write_type(wt[1]),
    .ramio_address(ad[1]), .ramio_data_in(dt[1]), .ramio_busy(rbusy[1]),
    .flash_clk(fclk[1]), .flash_miso(miso[1]), .flash_mosi(mosi[1]), .flash_cs(cs[1])
  );

  // Per-dut flash model, ramio scoreboard and flash_clk timing monitor.
  for (genvar g = 0; g < 2; g++) begin : fm
    localparam int HB  = (g == 1) ? 40 : 32;
    localparam int DIV = (g == 1) ? 3 : 1;
    int nbits = 0, dummy_bad = 0, unstable = 0, proto_bad = 0;
    int hi_run = 0, lo_run = 0, hi_bad = 0, lo_bad = 0, hi_runs = 0;
    logic [31:0] hdr = '0, paddr = '0, pdata = '0;
    logic miso_q = 1'b0, rb_q = 1'b0, stalled = 1'b0, pen = 1'b0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];

    assign miso[g]  = miso_q;
    assign rbusy[g] = rb_q;

    always @(negedge cs[g]) begin
      nbits = 0;
      hdr   = '0;
    end

    always @(posedge fclk[g]) begin
      if (!cs[g]) begin
        if (nbits < 32) hdr = {hdr[30:0], mosi[g]};
        else if (nbits < HB && mosi[g]) dummy_bad++;
        nbits++;
      end
    end

    always @(negedge fclk[g]) begin
      int d;
      logic [31:0] a;
      logic [7:0] b;
      if (!cs[g] && nbits >= HB) begin
        d = nbits - HB;
        a = {8'h0, hdr[23:0]} + 32'(d / 8);
        b = mem[a[8:0]];
        miso_q = b[3'(7 - (d % 8))];
      end
    end

    always @(negedge clk) begin
      if (en[g] && !rbusy[g]) begin
        wa.push_back(ad[g]);
        wd.push_back(dt[g]);
      end
      if (en[g] && pen && (ad[g] != paddr || dt[g] != pdata)) unstable++;
      if ((en[g] && wt[g] != 2'b11) || (!en[g] && wt[g] != 2'b00) || rt[g] != 3'b000) proto_bad++;
      pen = en[g]; paddr = ad[g]; pdata = dt[g];
      if (cs[g]) begin
        hi_run = 0;
        lo_run = 0;
      end else if (fclk[g]) begin
        if (lo_run > 0 && nbits <= HB && lo_run != DIV) lo_bad++;
        lo_run = 0;
        hi_run++;
      end else begin
        if (hi_run > 0) begin
          hi_runs++;
          if (hi_run != DIV) hi_bad++;
        end
        hi_run = 0;
        lo_run++;
      end
    end

    if (g == 1) begin : stall
      always begin
        @(posedge clk);
        #1;
        if (en[g] && !rb_q && !stalled) begin
          rb_q = 1'b1;
          stalled = 1'b1;
          repeat (5) @(posedge clk);
          #1;
          rb_q = 1'b0;
        end else if (!en[g]) begin
          stalled = 1'b0;
        end
      end
    end
  end

  typedef struct {
    string       name;
    int          dut;
    int          idx;
    logic [31:0] addr;
    logic [31:0] data;
  } wexp_t;
  wexp_t tbl[4];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic int wcount(input int g);
    return (g == 0) ? fm[0].wa.size() : fm[1].wa.size();
  endfunction

  function automatic logic [63:0] wrec(input int g, input int i);
    if (i >= wcount(g)) return 64'hdead_dead_dead_dead;
    return (g == 0) ? {fm[0].wa[i], fm[0].wd[i]} : {fm[1].wa[i], fm[1].wd[i]};
  endfunction

  function automatic logic [10:0] ctl(input int g);
    return {en[g], rt[g], wt[g], fclk[g], mosi[g], cs[g], busy[g], done[g]};
  endfunction

  task automatic check_reset(input int g, input string tag);
    chk({tag, "_ctl"}, 64'(ctl(g)), 64'(11'b000_0000_0110));
    chk({tag, "_addr_data"}, {ad[g], dt[g]}, 64'h0);
  endtask

  task automatic wait_done(input int g, input int lim, input string nm);
    int n = 0;
    while (!done[g] && n < lim) begin
      cyc();
      n++;
    end
    chk(nm, 64'(done[g]), 64'd1);
  endtask

  task automatic check_run(input int g, input int base, input string tag);
    chk({tag, "_nwr"}, 64'(wcount(g)), 64'(base + 2));
    chk({tag, "_end"}, 64'({cs[g], busy[g], done[g], en[g], fclk[g]}), 64'(5'b10100));
    for (int i = 0; i < 4; i++)
      if (tbl[i].dut == g)
        chk({tag, "_", tbl[i].name}, wrec(g, base + tbl[i].idx), {tbl[i].addr, tbl[i].data});
  endtask

  initial begin
    int n;
    int base;
    tbl[0] = '{"w0", 0, 0, 32'h0000_0000, 32'h4433_2211};
    tbl[1] = '{"w1", 0, 1, 32'h0000_0004, 32'h8877_6655};
    tbl[2] = '{"w0", 1, 0, 32'h0000_1000, 32'hd4c3_b2a1};
    tbl[3] = '{"w1", 1, 1, 32'h0000_1004, 32'h1807_f6e5};
    for (int i = 0; i < 512; i++) mem[i] = 8'(i * 7 + 3);
    for (int i = 0; i < 8; i++) mem[i] = 8'(8'h11 * (i + 1));
    mem[256] = 8'ha1; mem[257] = 8'hb2; mem[258] = 8'hc3; mem[259] = 8'hd4;
    mem[260] = 8'he5; mem[261] = 8'hf6; mem[262] = 8'h07; mem[263] = 8'h18;

    rst[0] = 1'b1; rst[1] = 1'b1; reload[0] = 1'b0; reload[1] = 1'b0;
    repeat (3) cyc();
    check_reset(0, "rst0");
    check_reset(1, "rst1");

    // Run 1: plain read after reset
    rst[0] = 1'b0;
    wait_done(0, 3000, "run1_done");
    chk("run1_cmd_addr", 64'(fm[0].hdr), 64'h0300_0000);
    check_run(0, 0, "run1");

    // Run 2: reload from Done starts immediately; reload while busy ignored
    cyc();
    reload[0] = 1'b1;
    cyc();
    reload[0] = 1'b0;
    chk("reload_start", 64'({busy[0], done[0], cs[0]}), 64'(3'b100));
    repeat (20) cyc();
    reload[0] = 1'b1;
    cyc();
    reload[0] = 1'b0;
    chk("reload_busy_ignored", 64'({busy[0], done[0]}), 64'(2'b10));
    wait_done(0, 3000, "run2_done");
    chk("run2_cmd_addr", 64'(fm[0].hdr), 64'h0300_0000);
    check_run(0, 2, "run2");

    // Run 3: async reset during the second word's read
    cyc();
    reload[0] = 1'b1;
    cyc();
    reload[0] = 1'b0;
    n = 0;
    while (wcount(0) < 5 && n < 3000) begin
      cyc();
      n++;
    end
    repeat (10) cyc();
    chk("mid_word2", 64'({busy[0], cs[0], done[0]}), 64'(3'b100));
    #3;
    rst[0] = 1'b1;
    #1;
    check_reset(0, "midrst");
    base = wcount(0);
    chk("midrst_nwr", 64'(base), 64'd5);
    cyc();
    rst[0] = 1'b0;
    wait_done(0, 3000, "run3_done");
    chk("run3_cmd_addr", 64'(fm[0].hdr), 64'h0300_0000);
    check_run(0, base, "run3");
    chk("div1_timing", 64'({fm[0].hi_bad, fm[0].lo_bad}), 64'h0);
    chk("ramio0_proto", 64'(fm[0].proto_bad), 64'h0);

    // dut 1: fast read, divided clock, stalled writes
    rst[1] = 1'b0;
    wait_done(1, 10000, "fast_done");
    chk("fast_cmd_addr", 64'(fm[1].hdr), 64'h0B00_0100);
    chk("fast_dummy_mosi", 64'(fm[1].dummy_bad), 64'h0);
    check_run(1, 0, "fast");
    chk("stall_stable", 64'(fm[1].unstable), 64'h0);
    chk("ramio1_proto", 64'(fm[1].proto_bad), 64'h0);
    chk("div3_timing", 64'({fm[1].hi_bad, fm[1].lo_bad}), 64'h0);
    chk("div3_clocks", 64'(fm[1].hi_runs), 64'd104);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
